tdc_ctrl_csr: RTL and testbench

TDC_CTRL_CSR -- requirements
Module: tdc_ctrl_csr

---
 rtl/tdc_ctrl_csr.sv | 126 ++++++++++++
 tb/tb_tdc_ctrl_csr.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tdc_ctrl_csr.sv
// rtl/tdc_ctrl_csr.sv - serial config CSR for the TDC control word (optional parity via TDC_CSR_PARITY_EN)
module tdc_ctrl_csr #(
    parameter int RESERVED_OK = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_sdi,
    input  logic       cfg_sen,
    input  logic       cfg_latch,
    output logic       cfg_sdo,
    output logic       cfg_ack,
    output logic       cfg_err,
    output logic       ctl_pls_src,
    output logic       ctl_tog,
    output logic [1:0] ctl_delay_line,
    output logic       ctl_valid
);

`ifdef TDC_CSR_PARITY_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    state_t                 state, state_next;
    logic [1:0]             rst_sync;
    logic                   run;
    logic [FRAME_LEN-1:0]   sr, sr_next;
    logic [2:0]             count, count_next;
    logic [3:0]             ctl_word, ctl_next;
    logic                   valid_next, ack_next, err_next;
    logic [3:0]             frame_word;
    logic                   code_ok, parity_ok, frame_ok;

    // Shift register image of a word: data MSB first, parity bit (if any) last.
    function automatic logic [FRAME_LEN-1:0] pack(input logic [3:0] w);
`ifdef TDC_CSR_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // Reset release is resynchronised; control logic stays idle until it propagates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run = rst_sync[1];

    assign frame_word = sr[FRAME_LEN-1 -: 4];
    assign code_ok    = (RESERVED_OK != 0) || !frame_word[1];
`ifdef TDC_CSR_PARITY_EN
    assign parity_ok  = ~^sr;
`else
    assign parity_ok  = 1'b1;
`endif
    assign frame_ok   = !cfg_sen && (count == 3'(FRAME_LEN)) && code_ok && parity_ok;

    always_comb begin
        state_next = state;
        sr_next    = sr;
        count_next = count;
        ctl_next   = ctl_word;
        valid_next = ctl_valid;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE, SHIFT: begin
                if (run && cfg_latch) begin
                    state_next = RESP;
                    count_next = 3'd0;
                    if (frame_ok) begin
                        ctl_next   = frame_word;
                        valid_next = 1'b1;
                        ack_next   = 1'b1;
                        sr_next    = pack(frame_word);
                    end else begin
                        err_next   = 1'b1;
                        sr_next    = pack(ctl_word);
                    end
                end else if (run && cfg_sen) begin
                    state_next = SHIFT;
                    sr_next    = {sr[FRAME_LEN-2:0], cfg_sdi};
                    count_next = (count == 3'd7) ? 3'd7 : count + 3'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
                count_next = 3'd0;
            end
            default: begin
                state_next = IDLE;
                count_next = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            count     <= 3'd0;
            ctl_word  <= 4'd0;
            ctl_valid <= 1'b0;
            cfg_ack   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_next;
            sr        <= sr_next;
            count     <= count_next;
            ctl_word  <= ctl_next;
            ctl_valid <= valid_next;
            cfg_ack   <= ack_next;
            cfg_err   <= err_next;
        end
    end

    assign cfg_sdo        = sr[FRAME_LEN-1];
    assign ctl_pls_src    = ctl_word[3];
    assign ctl_tog        = ctl_word[2];
    assign ctl_delay_line = ctl_word[1:0];

endmodule

// File: tb/tb_tdc_ctrl_csr.sv
// tb/tb_tdc_ctrl_csr.sv - bench for tdc_ctrl_csr, both RESERVED_OK settings side by side
module tb_tdc_ctrl_csr;

`ifdef TDC_CSR_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic clk = 1'b0;
    logic rst_n, sdi, sen, latch;
    logic sdo0, ack0, err0, pls0, tog0, valid0;
    logic sdo1, ack1, err1, pls1, tog1, valid1;
    logic [1:0] dly0, dly1;
    logic [7:0] o0, o1;

    int checks = 0;
    int errors = 0;

    int       n;
    int       sr_m [2];
    int       act  [2];
    bit       val  [2];
    bit       ea   [2];
    bit       ee   [2];

    always #5 clk = ~clk;

    tdc_ctrl_csr #(.RESERVED_OK(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_sdi(sdi), .cfg_sen(sen), .cfg_latch(latch),
        .cfg_sdo(sdo0), .cfg_ack(ack0), .cfg_err(err0), .ctl_pls_src(pls0),
        .ctl_tog(tog0), .ctl_delay_line(dly0), .ctl_valid(valid0)
    );

    tdc_ctrl_csr #(.RESERVED_OK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_sdi(sdi), .cfg_sen(sen), .cfg_latch(latch),
        .cfg_sdo(sdo1), .cfg_ack(ack1), .cfg_err(err1), .ctl_pls_src(pls1),
        .ctl_tog(tog1), .ctl_delay_line(dly1), .ctl_valid(valid1)
    );

    assign o0 = {sdo0, pls0, tog0, dly0, valid0, ack0, err0};
    assign o1 = {sdo1, pls1, tog1, dly1, valid1, ack1, err1};

    function automatic int pack_m(input int w);
`ifdef TDC_CSR_PARITY_EN
        return (w << 1) | ($countones(w) % 2);
`else
        return w;
`endif
    endfunction

    function automatic logic [7:0] expv(input int d, input bit a, input bit e);
        logic [7:0] v;
        v[7]   = 1'((sr_m[d] >> (FL - 1)) & 1);
        v[6:3] = 4'(act[d]);
        v[2]   = val[d];
        v[1]   = a;
        v[0]   = e;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_r0"}, o0, expv(0, ea[0], ee[0]));
        chk({tag, "_r1"}, o1, expv(1, ea[1], ee[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        n = 0;
        for (int d = 0; d < 2; d++) begin
            sr_m[d] = 0; act[d] = 0; val[d] = 0; ea[d] = 0; ee[d] = 0;
        end
    endtask

    task automatic shift_bit(input bit b);
        ea = '{0, 0}; ee = '{0, 0};
        chk_all("pre_shift");
        sen = 1'b1; sdi = b;
        tick();
        sen = 1'b0;
        n = (n < 7) ? n + 1 : 7;
        for (int d = 0; d < 2; d++) sr_m[d] = ((sr_m[d] << 1) | int'(b)) & ((1 << FL) - 1);
    endtask

    task automatic send_word(input int w);
        for (int i = 3; i >= 0; i--) shift_bit(bit'((w >> i) & 1));
`ifdef TDC_CSR_PARITY_EN
        shift_bit(bit'($countones(w) % 2));
`endif
    endtask

    task automatic do_latch(input bit both, input string tag);
        int  w;
        bit  ok;
        sen = both; latch = 1'b1;
        tick();
        latch = 1'b0;
        sen = 1'($urandom); sdi = 1'($urandom);
        for (int d = 0; d < 2; d++) begin
            w  = (sr_m[d] >> (FL - 4)) & 15;
            ok = !both && (n == FL) && ((w & 2) == 0 || d == 1);
`ifdef TDC_CSR_PARITY_EN
            ok = ok && ($countones(sr_m[d]) % 2 == 0);
`endif
            if (ok) begin
                act[d] = w; val[d] = 1'b1;
            end
            ea[d] = ok; ee[d] = !ok;
            sr_m[d] = pack_m(act[d]);
        end
        n = 0;
        chk_all({tag, "_resp"});
        tick();
        sen = 1'b0;
        ea = '{0, 0}; ee = '{0, 0};
        chk_all({tag, "_after"});
    endtask

    initial begin
        rst_n = 1'b0; sdi = 1'b0; sen = 1'b0; latch = 1'b0;
        model_reset();
        tick(); tick();
        chk_all("reset");
        rst_n = 1'b1;
        tick(); tick();
        chk_all("sync_release");

        for (int i = 0; i < 3; i++) shift_bit(1'b1);
        do_latch(1'b0, "short3");
        do_latch(1'b0, "empty");
        send_word(4'b0110);
        do_latch(1'b0, "reserved");
        send_word(4'b1001);
        do_latch(1'b0, "w1001");
        send_word(4'b1101);
        do_latch(1'b0, "w1101");
        send_word(4'b0001);
        do_latch(1'b0, "readback");
        send_word(4'b0100);
        shift_bit(1'b0);
        do_latch(1'b0, "long");
        for (int i = 0; i < 9; i++) shift_bit(1'($urandom));
        do_latch(1'b0, "saturate");
        send_word(4'b0001);
        do_latch(1'b1, "collide");
`ifdef TDC_CSR_PARITY_EN
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1);
        do_latch(1'b0, "par_bad");
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b0);
        do_latch(1'b0, "par_good");
`endif

        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                send_word(int'($urandom_range(0, 15)));
            end else begin
                int len = int'($urandom_range(0, 7));
                for (int i = 0; i < len; i++) shift_bit(1'($urandom));
            end
            do_latch(($urandom_range(0, 7) == 0), "rand");
        end

        send_word(4'b1010);
        do_latch(1'b0, "pre_rst");
        shift_bit(1'b1); shift_bit(1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        chk_all("rst_rel1");
        tick();
        chk_all("rst_rel2");
        send_word(4'b0101);
        do_latch(1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
